// File: rtl/gpio_conv_ctrl_pkg.sv
// gpio_conv_ctrl_pkg: command codes, FSM states and GPIO field positions for gpio_conv_ctrl
package gpio_conv_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        C_KERNEL = 3'b000,
        C_SIZE   = 3'b001,
        C_LOAD   = 3'b010,
        C_READ   = 3'b011,
        C_LAST   = 3'b100
    } cmd_t;
    localparam int CTRL_LSB  = 29;
    localparam int VALID_BIT = 28;
    localparam int DATA_LSB  = 1;
    localparam int DATA_BITS = 24;
    localparam int SRST_BIT  = 0;
endpackage

// File: rtl/gpio_conv_ctrl_strobe_det.sv
// gpio_strobe_det: one-cycle strobe on the rising edge of the GPIO valid bit
module gpio_strobe_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_strobe
);
    logic r_valid_q;
    // Delay valid by one cycle for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_valid_q <= 1'b0;
        else          r_valid_q <= i_valid;
    end
    assign o_strobe = i_valid & ~r_valid_q;
endmodule

// File: rtl/gpio_conv_ctrl.sv
// gpio_conv_ctrl: GPIO command sequencer for the 2D-conv datapath; GPIO_CTRL_ERR_EN adds a sticky error flag on o_gpio_data[31]
module gpio_conv_ctrl #(
    parameter int GPIO_D = 32,
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int OUT_W  = 13,
    parameter int K_W    = 24
) (
    input  logic                      CLK100MHZ,
    input  logic                      rst_n,
    input  logic [GPIO_D-1:0]         i_gpio_data,
    output logic [GPIO_D-1:0]         o_gpio_data,
    output logic                      o_led,
    output logic                      o_kernel_we,
    output logic [1:0]                o_kernel_row,
    output logic [K_W-1:0]            o_kernel_data,
    output logic [ADDR_W-1:0]         o_img_size,
    output logic                      o_mem_we,
    output logic [$clog2(N+2)-1:0]    o_mem_sel,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    output logic                      o_conv_start,
    input  logic                      i_conv_done,
    output logic [$clog2(N)-1:0]      o_rd_sel,
    output logic [ADDR_W-1:0]         o_rd_addr,
    input  logic [OUT_W-1:0]          i_rd_data
);
    import gpio_conv_ctrl_pkg::*;
    localparam int WS_W = $clog2(N+2);
    localparam int RS_W = $clog2(N);
    localparam logic [WS_W-1:0] WS_LAST = WS_W'(N+1);
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(N-1);
    state_t r_state, w_next;
    cmd_t w_cmd;
    logic w_rst_n, w_strobe, w_load_cmd, w_k_wr, w_size_wr, w_px_wr, w_last, w_done_go, w_rd_adv;
    logic w_wr_wrap, w_rd_wrap, w_rd_end, w_unused;
    logic [DATA_BITS-1:0] w_data;
    logic [1:0] r_k_row, r_kernel_row;
    logic [K_W-1:0] r_kernel_data;
    logic [ADDR_W-1:0] r_img_size, r_wr_addr, r_mem_addr, r_rd_addr;
    logic [WS_W-1:0] r_wr_sel, r_mem_sel;
    logic [RS_W-1:0] r_rd_sel;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [OUT_W-1:0] r_result;
    logic r_kernel_we, r_mem_we, r_start_pend, r_conv_start, r_led;

    assign w_rst_n    = rst_n & ~i_gpio_data[SRST_BIT];
    assign w_cmd      = cmd_t'(i_gpio_data[CTRL_LSB +: 3]);
    assign w_data     = i_gpio_data[DATA_LSB +: DATA_BITS];
    assign w_unused   = &{1'b0, i_gpio_data[27:25]};
    assign w_load_cmd = w_strobe && (w_cmd == C_LOAD || w_cmd == C_LAST);
    assign w_wr_wrap  = r_wr_addr == r_img_size;
    assign w_rd_wrap  = r_rd_addr == r_img_size - ADDR_W'(2);
    assign w_rd_end   = w_rd_wrap && r_rd_sel == RS_LAST;

    gpio_strobe_det u_strobe (
        .i_clk    (CLK100MHZ),
        .i_rst_n  (w_rst_n),
        .i_valid  (i_gpio_data[VALID_BIT]),
        .o_strobe (w_strobe)
    );

    // Decode the strobed command against the current state and pick the next state
    always_comb begin
        w_k_wr    = 1'b0;
        w_size_wr = 1'b0;
        w_px_wr   = 1'b0;
        w_done_go = 1'b0;
        w_rd_adv  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_k_wr    = w_strobe && w_cmd == C_KERNEL;
                w_size_wr = w_strobe && w_cmd == C_SIZE;
                w_px_wr   = w_load_cmd;
            end
            S_LOAD:  w_px_wr   = w_load_cmd;
            S_RUN:   w_done_go = i_conv_done;
            S_DONE:  w_rd_adv  = w_strobe && w_cmd == C_READ;
            default: ;
        endcase
        w_last = w_px_wr && w_cmd == C_LAST;
        w_next = w_last ? S_RUN : w_px_wr ? S_LOAD : w_done_go ? S_DONE :
                 (w_rd_adv && w_rd_end) ? S_IDLE : r_state;
    end

    // State, write/read pointers and registered datapath strobes
    always_ff @(posedge CLK100MHZ) begin
        if (!w_rst_n) begin
            r_state       <= S_IDLE;
            r_k_row       <= '0;
            r_kernel_we   <= 1'b0;
            r_kernel_row  <= '0;
            r_kernel_data <= '0;
            r_img_size    <= '0;
            r_mem_we      <= 1'b0;
            r_wr_sel      <= '0;
            r_wr_addr     <= '0;
            r_mem_sel     <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_start_pend  <= 1'b0;
            r_conv_start  <= 1'b0;
            r_led         <= 1'b0;
            r_rd_sel      <= '0;
            r_rd_addr     <= '0;
            r_result      <= '0;
        end else begin
            r_state      <= w_next;
            r_kernel_we  <= w_k_wr;
            r_mem_we     <= w_px_wr;
            r_start_pend <= w_last;
            r_conv_start <= r_start_pend;
            if (w_k_wr) begin
                r_kernel_row  <= r_k_row;
                r_kernel_data <= w_data[K_W-1:0];
                r_k_row       <= r_k_row == 2'd2 ? 2'd0 : r_k_row + 2'd1;
            end
            if (w_size_wr) r_img_size <= w_data[ADDR_W-1:0];
            if (w_px_wr) begin
                r_mem_sel   <= r_wr_sel;
                r_mem_addr  <= r_wr_addr;
                r_mem_wdata <= w_data[DATA_W-1:0];
                r_wr_addr   <= w_wr_wrap ? '0 : r_wr_addr + ADDR_W'(1);
                r_wr_sel    <= !w_wr_wrap ? r_wr_sel : r_wr_sel == WS_LAST ? '0 : r_wr_sel + WS_W'(1);
            end
            if (w_done_go) begin
                r_led     <= 1'b1;
                r_rd_sel  <= '0;
                r_rd_addr <= '0;
            end
            if (w_rd_adv) begin
                r_led     <= !w_rd_end;
                r_rd_addr <= w_rd_wrap ? '0 : r_rd_addr + ADDR_W'(1);
                r_rd_sel  <= w_rd_end ? '0 : w_rd_wrap ? r_rd_sel + RS_W'(1) : r_rd_sel;
            end
            if (r_state == S_DONE) r_result <= i_rd_data;
        end
    end

`ifdef GPIO_CTRL_ERR_EN
    logic r_err, w_bad;
    assign w_bad = (w_strobe && !(w_k_wr || w_size_wr || w_px_wr || w_rd_adv || w_done_go)) ||
                   (w_px_wr && r_img_size == '0);
    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK100MHZ) begin
        if (!w_rst_n) r_err <= 1'b0;
        else          r_err <= r_err | w_bad;
    end
    assign o_gpio_data = {r_err, {(GPIO_D-1-OUT_W){1'b0}}, r_result};
`else
    assign o_gpio_data = {1'b0, {(GPIO_D-1-OUT_W){1'b0}}, r_result};
`endif

    assign o_led         = r_led;
    assign o_kernel_we   = r_kernel_we;
    assign o_kernel_row  = r_kernel_row;
    assign o_kernel_data = r_kernel_data;
    assign o_img_size    = r_img_size;
    assign o_mem_we      = r_mem_we;
    assign o_mem_sel     = r_mem_sel;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_conv_start  = r_conv_start;
    assign o_rd_sel      = r_rd_sel;
    assign o_rd_addr     = r_rd_addr;
endmodule
